// File: rtl/cache_trace_profiler.sv
// Set-associative cache model driven by an address trace in SRAM; LRU or FIFO replacement.
// Latency: 1 flush cycle, then 4 cycles per trace entry (FETCH, WAIT, LOOKUP, UPDATE).
// Backpressure: none; start is ignored while busy, and done holds until the next accepted start.
module cache_trace_profiler #(
  parameter int ADDR_W   = 32,
  parameter int TRACE_AW = 8,
  parameter int LINE_W   = 2,
  parameter int SET_W    = 2,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TRACE_AW:0]   trace_len,
  input  logic                repl_mode,
  output logic                mem_csb,
  output logic [TRACE_AW-1:0] mem_addr,
  input  logic [ADDR_W-1:0]   mem_dout,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    access_count,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    evict_count
);

  localparam int SETS  = 1 << SET_W;
  localparam int TAG_W = ADDR_W - LINE_W - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAY_W-1:0] way_t;
  localparam way_t AGE_MAX = way_t'(WAYS - 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FLUSH, ST_FETCH, ST_WAIT, ST_LOOKUP, ST_UPDATE, ST_DONE
  } state_t;

  state_t              state;
  logic [TRACE_AW:0]   len_q;
  logic [TRACE_AW:0]   idx_q;
  logic [TRACE_AW:0]   idx_nxt;
  logic                repl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                hit_q;
  way_t                hit_way_q;
  way_t                victim_q;
  logic                victim_vld_q;

  line_t               lines    [SETS][WAYS];
  way_t                age      [SETS][WAYS];
  way_t                fifo_ptr [SETS];

  logic [SET_W-1:0]    set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic                unused_offset;

  logic                lk_hit;
  way_t                lk_hit_way;
  logic                lk_has_inv;
  way_t                lk_inv_way;
  way_t                lk_lru_way;
  way_t                lk_victim;

  way_t                upd_way;
  way_t                upd_old_age;
  way_t                ptr_nxt;

  assign set_idx       = addr_q[LINE_W +: SET_W];
  assign tag_in        = addr_q[LINE_W+SET_W +: TAG_W];
  assign unused_offset = ^addr_q[LINE_W-1:0];
  assign idx_nxt       = idx_q + 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Descending scans so the lowest-index match wins for both hit and invalid-way search.
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    lk_has_inv = 1'b0;
    lk_inv_way = '0;
    lk_lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lines[set_idx][w].vld && (lines[set_idx][w].tag == tag_in)) begin
        lk_hit     = 1'b1;
        lk_hit_way = way_t'(w);
      end
      if (!lines[set_idx][w].vld) begin
        lk_has_inv = 1'b1;
        lk_inv_way = way_t'(w);
      end
      if (age[set_idx][w] == AGE_MAX) begin
        lk_lru_way = way_t'(w);
      end
    end
    if (lk_has_inv) begin
      lk_victim = lk_inv_way;
    end else if (repl_q) begin
      lk_victim = fifo_ptr[set_idx];
    end else begin
      lk_victim = lk_lru_way;
    end
  end

  // A filled line is treated as if it came from the oldest age, so every other way ages
  // by one; this keeps valid-way ages equal to their recency rank while the set fills.
  always_comb begin
    upd_way     = hit_q ? hit_way_q : victim_q;
    upd_old_age = hit_q ? age[set_idx][hit_way_q] : AGE_MAX;
    ptr_nxt     = (fifo_ptr[set_idx] == AGE_MAX) ? '0 : fifo_ptr[set_idx] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mem_csb      <= 1'b1;
      mem_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      access_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      evict_count  <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      repl_q       <= 1'b0;
      addr_q       <= '0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      victim_q     <= '0;
      victim_vld_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w] <= '0;
          age[s][w]   <= '0;
        end
      end
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_FLUSH;
            busy         <= 1'b1;
            done         <= 1'b0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            evict_count  <= '0;
            len_q        <= trace_len;
            repl_q       <= repl_mode;
            idx_q        <= '0;
          end
        end

        ST_FLUSH: begin
          for (int s = 0; s < SETS; s++) begin
            fifo_ptr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
              lines[s][w].vld <= 1'b0;
              age[s][w]       <= '0;
            end
          end
          if (len_q == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            mem_csb  <= 1'b0;
            mem_addr <= idx_q[TRACE_AW-1:0];
          end
        end

        ST_FETCH: begin
          mem_csb <= 1'b1;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          addr_q <= mem_dout;
          state  <= ST_LOOKUP;
        end

        ST_LOOKUP: begin
          hit_q        <= lk_hit;
          hit_way_q    <= lk_hit_way;
          victim_q     <= lk_victim;
          victim_vld_q <= !lk_has_inv;
          state        <= ST_UPDATE;
        end

        ST_UPDATE: begin
          access_count <= sat_inc(access_count);
          if (hit_q) begin
            hit_count <= sat_inc(hit_count);
          end else begin
            miss_count <= sat_inc(miss_count);
            if (victim_vld_q) begin
              evict_count <= sat_inc(evict_count);
            end
            lines[set_idx][victim_q] <= '{vld: 1'b1, tag: tag_in};
            fifo_ptr[set_idx]        <= ptr_nxt;
          end
          if (!repl_q) begin
            for (int w = 0; w < WAYS; w++) begin
              if (way_t'(w) == upd_way) begin
                age[set_idx][w] <= '0;
              end else if (age[set_idx][w] < upd_old_age) begin
                age[set_idx][w] <= age[set_idx][w] + 1'b1;
              end
            end
          end
          idx_q <= idx_nxt;
          if (idx_nxt == len_q) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            mem_csb  <= 1'b0;
            mem_addr <= idx_nxt[TRACE_AW-1:0];
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_trace_profiler.sv
// Bench for cache_trace_profiler: directed scenarios plus random traces scored against
// a per-set recency/insertion-order queue model of the cache.
module tb_cache_trace_profiler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_s;
  logic [8:0]  trace_len;
  logic        repl_mode;

  logic        mem_csb, mem_csb_s;
  logic [7:0]  mem_addr, mem_addr_s;
  logic [31:0] mem_dout, mem_dout_s;
  logic        busy, done, busy_s, done_s;
  logic [9:0]  acc, hit, mis, evc;
  logic [2:0]  acc_s, hit_s, mis_s, evc_s;

  logic [31:0] mem_a [256];
  logic [31:0] mem_s [256];

  int n_chk = 0;
  int n_err = 0;
  int csb_lows = 0;
  logic busy_at_e;
  int   acc_at_e;

  always #5 clk = ~clk;

  cache_trace_profiler dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len), .repl_mode(repl_mode),
    .mem_csb(mem_csb), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .busy(busy), .done(done),
    .access_count(acc), .hit_count(hit), .miss_count(mis), .evict_count(evc)
  );

  cache_trace_profiler #(.CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .trace_len(trace_len), .repl_mode(repl_mode),
    .mem_csb(mem_csb_s), .mem_addr(mem_addr_s), .mem_dout(mem_dout_s),
    .busy(busy_s), .done(done_s),
    .access_count(acc_s), .hit_count(hit_s), .miss_count(mis_s), .evict_count(evc_s)
  );

  // Synchronous-read SRAM models
  always @(posedge clk) begin
    if (!mem_csb)   mem_dout   <= mem_a[mem_addr];
    if (!mem_csb_s) mem_dout_s <= mem_s[mem_addr_s];
    if (!mem_csb)   csb_lows   <= csb_lows + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  // Starts a run at edge E and returns the number of cycles until done is seen.
  // poke_at >= 0 pulses start (with a different length) that many cycles after E.
  task automatic run(input bit sel, input int len, input logic mode, input int poke_at,
                     output int lat);
    @(negedge clk);
    trace_len = 9'(len);
    repl_mode = mode;
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_s = 1'b0;
    busy_at_e = sel ? busy_s : busy;
    acc_at_e  = sel ? int'(acc_s) : int'(acc);
    lat = 0;
    while (!(sel ? done_s : done) && lat < 5000) begin
      if (lat == poke_at) begin
        start = 1'b1;
        trace_len = 9'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    n_chk++;
    if (lat >= 5000) begin
      n_err++;
      $display("FAIL run_timeout: got %0d cycles expected done within 5000", lat);
    end
  endtask

  // Reference: each set is a queue of tags, oldest/least-recent at the front.
  task automatic model(input bit sel, input int len, input logic mode, input int ways,
                       input int maxc, output int a, output int h, output int m, output int e);
    logic [31:0] q [4][$];
    logic [31:0] addr, tag;
    int s, pos;
    a = 0; h = 0; m = 0; e = 0;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int i = 0; i < len; i++) begin
      addr = sel ? mem_s[i] : mem_a[i];
      s    = int'((addr >> 2) & 32'd3);
      tag  = addr >> 4;
      pos  = -1;
      for (int k = 0; k < q[s].size(); k++) if (q[s][k] == tag) pos = k;
      a++;
      if (pos >= 0) begin
        h++;
        if (mode == 1'b0) begin
          q[s].delete(pos);
          q[s].push_back(tag);
        end
      end else begin
        m++;
        if (q[s].size() == ways) begin
          void'(q[s].pop_front());
          e++;
        end
        q[s].push_back(tag);
      end
    end
    if (a > maxc) a = maxc;
    if (h > maxc) h = maxc;
    if (m > maxc) m = maxc;
    if (e > maxc) e = maxc;
  endtask

  task automatic load_trace1();
    mem_a[0] = 32'h00; mem_a[1] = 32'h04; mem_a[2] = 32'h00; mem_a[3] = 32'h01;
  endtask

  task automatic test_reset();
    n_chk++; if (mem_csb !== 1'b1) begin n_err++; $display("FAIL reset_csb: got %b expected 1", mem_csb); end
    n_chk++; if (mem_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    n_chk++; if ({acc, hit, mis, evc} !== 40'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0", acc, hit, mis, evc); end
    n_chk++; if (busy_s !== 1'b0 || done_s !== 1'b0 || mem_csb_s !== 1'b1) begin n_err++; $display("FAIL reset_sat_dut: got busy=%b done=%b csb=%b expected 0 0 1", busy_s, done_s, mem_csb_s); end
  endtask

  task automatic test_basic();
    int lat, c0;
    load_trace1();
    c0 = csb_lows;
    run(1'b0, 4, 1'b0, -1, lat);
    n_chk++; if (busy_at_e !== 1'b1) begin n_err++; $display("FAIL basic_busy_at_start: got %b expected 1", busy_at_e); end
    n_chk++; if (lat != 17) begin n_err++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    n_chk++; if (csb_lows - c0 != 4) begin n_err++; $display("FAIL basic_fetches: got %0d expected 4", csb_lows - c0); end
    n_chk++; if (acc !== 10'd4 || hit !== 10'd2 || mis !== 10'd2 || evc !== 10'd0) begin
      n_err++; $display("FAIL basic_counts: got %0d/%0d/%0d/%0d expected 4/2/2/0", acc, hit, mis, evc);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run(1'b0, 4, 1'b0, -1, lat);
    n_chk++; if (acc_at_e != 0) begin n_err++; $display("FAIL b2b_cleared: got %0d expected 0", acc_at_e); end
    n_chk++; if (lat != 17) begin n_err++; $display("FAIL b2b_latency: got %0d expected 17", lat); end
    n_chk++; if (acc !== 10'd4 || hit !== 10'd2 || mis !== 10'd2 || evc !== 10'd0) begin
      n_err++; $display("FAIL b2b_counts: got %0d/%0d/%0d/%0d expected 4/2/2/0", acc, hit, mis, evc);
    end
  endtask

  task automatic test_conflict();
    int lat;
    mem_a[0] = 32'h00; mem_a[1] = 32'h10; mem_a[2] = 32'h00; mem_a[3] = 32'h20; mem_a[4] = 32'h10;
    run(1'b0, 5, 1'b0, -1, lat);
    n_chk++; if (acc !== 10'd5 || hit !== 10'd1 || mis !== 10'd4 || evc !== 10'd2) begin
      n_err++; $display("FAIL conflict_lru: got %0d/%0d/%0d/%0d expected 5/1/4/2", acc, hit, mis, evc);
    end
    run(1'b0, 5, 1'b1, -1, lat);
    n_chk++; if (acc !== 10'd5 || hit !== 10'd2 || mis !== 10'd3 || evc !== 10'd1) begin
      n_err++; $display("FAIL conflict_fifo: got %0d/%0d/%0d/%0d expected 5/2/3/1", acc, hit, mis, evc);
    end
  endtask

  task automatic test_saturate();
    int lat;
    for (int i = 0; i < 10; i++) mem_s[i] = 32'h40;
    run(1'b1, 10, 1'b0, -1, lat);
    n_chk++; if (lat != 41) begin n_err++; $display("FAIL sat_latency: got %0d expected 41", lat); end
    n_chk++; if (acc_s !== 3'd7 || hit_s !== 3'd7 || mis_s !== 3'd1 || evc_s !== 3'd0) begin
      n_err++; $display("FAIL sat_counts: got %0d/%0d/%0d/%0d expected 7/7/1/0", acc_s, hit_s, mis_s, evc_s);
    end
  endtask

  task automatic test_zero_len();
    int lat, c0;
    c0 = csb_lows;
    run(1'b0, 0, 1'b0, -1, lat);
    n_chk++; if (lat != 1) begin n_err++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    n_chk++; if ({acc, hit, mis, evc} !== 40'd0) begin n_err++; $display("FAIL zero_counts: got %0d/%0d/%0d/%0d expected 0", acc, hit, mis, evc); end
    n_chk++; if (csb_lows != c0) begin n_err++; $display("FAIL zero_fetches: got %0d expected 0", csb_lows - c0); end
  endtask

  task automatic test_start_busy();
    int lat;
    load_trace1();
    run(1'b0, 4, 1'b0, 5, lat);
    n_chk++; if (lat != 17) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 17", lat); end
    n_chk++; if (acc !== 10'd4 || hit !== 10'd2 || mis !== 10'd2 || evc !== 10'd0) begin
      n_err++; $display("FAIL busy_start_counts: got %0d/%0d/%0d/%0d expected 4/2/2/0", acc, hit, mis, evc);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_trace1();
    @(negedge clk);
    trace_len = 9'd4; repl_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_chk++; if (acc !== 10'd2) begin n_err++; $display("FAIL midrun_progress: got %0d expected 2", acc); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || mem_csb !== 1'b1) begin
      n_err++; $display("FAIL midrun_reset_ctrl: got busy=%b done=%b csb=%b expected 0 0 1", busy, done, mem_csb);
    end
    n_chk++; if ({acc, hit, mis, evc} !== 40'd0) begin
      n_err++; $display("FAIL midrun_reset_counts: got %0d/%0d/%0d/%0d expected 0", acc, hit, mis, evc);
    end
    run(1'b0, 4, 1'b0, -1, lat);
    n_chk++; if (lat != 17 || acc !== 10'd4 || hit !== 10'd2 || mis !== 10'd2 || evc !== 10'd0) begin
      n_err++; $display("FAIL midrun_rerun: got lat=%0d %0d/%0d/%0d/%0d expected 17 4/2/2/0", lat, acc, hit, mis, evc);
    end
  endtask

  task automatic test_random();
    int lat, len, ea, eh, em, ee;
    logic mode;
    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(1, 40);
      mode = it[0];
      for (int i = 0; i < len; i++)
        mem_a[i] = ($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      model(1'b0, len, mode, 2, 1023, ea, eh, em, ee);
      run(1'b0, len, mode, -1, lat);
      n_chk++; if (lat != 1 + 4 * len) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, 1 + 4 * len); end
      n_chk++; if (int'(acc) !== ea || int'(hit) !== eh || int'(mis) !== em || int'(evc) !== ee) begin
        n_err++; $display("FAIL rand_counts[%0d] mode=%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                          it, mode, acc, hit, mis, evc, ea, eh, em, ee);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_s = 1'b0; trace_len = '0; repl_mode = 1'b0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_s[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_conflict();
    test_saturate();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_trace_profiler.md
# cache_trace_profiler

Parametrised set-associative cache profiler, successor to the fixed-geometry L1/L2 hit counter. It walks an address trace stored in the on-chip trace SRAM and models one cache of configurable sets, ways, line size and replacement policy. It reports access, hit, miss and eviction counts to the logic analyzer. It sits between the trace SRAM read port and the LA output bus in the user project wrapper.

## Interface
- ADDR_W, 32, trace word / address width
- TRACE_AW, 8, trace SRAM address width (max 2^TRACE_AW entries)
- LINE_W, 2, log2 bytes per line (offset bits)
- SET_W, 2, log2 number of sets
- WAYS, 2, associativity; power of two, ≥1
- CNT_W, 10, statistic counter width
- clk  in  1  system clock (wb_clk_i)
- reset  in  1  synchronous, active-high
- start  in  1  run request, sampled in IDLE or DONE only
- trace_len  in  TRACE_AW+1  entries to process, 0..2^TRACE_AW, sampled with start
- repl_mode  in  1  0=LRU, 1=FIFO, sampled with start
- mem_csb  out  1  SRAM chip select, active low
- mem_addr  out  TRACE_AW  SRAM read address
- mem_dout  in  ADDR_W  SRAM read data, valid one cycle after the csb-low cycle
- busy  out  1  run in progress
- done  out  1  run complete, held until next accepted start or reset
- access_count, hit_count, miss_count, evict_count  out  CNT_W each  statistics

## Operation
- States: IDLE, FLUSH, FETCH, WAIT, LOOKUP, UPDATE, DONE.
- IDLE/DONE + start=1: clear all counters, latch trace_len/repl_mode, index=0, go FLUSH.
- FLUSH: clear all valid bits, LRU ages and FIFO pointers. Next state is FETCH, or DONE if trace_len=0.
- FETCH: mem_csb=0, mem_addr=index. WAIT: capture mem_dout into the address register at the end of the cycle.
- Address split: offset=[LINE_W-1:0]; set=[LINE_W+SET_W-1:LINE_W]; tag=[ADDR_W-1:LINE_W+SET_W].
- LOOKUP: compare tag against all valid ways of the set in parallel. Register hit and hit_way. Compute victim: lowest-index invalid way, else the LRU way (age=WAYS-1) in LRU mode, else the set FIFO pointer in FIFO mode.
- UPDATE:
  - access_count+1.
  - On hit: hit_count+1.
  - On miss: miss_count+1; evict_count+1 if victim valid; write tag and set valid in victim way; FIFO pointer+1 mod WAYS.
  - LRU: touched way age←0; ways with age < old age of touched way +1.
  - FIFO: hits do not change order.
  - index+1; next state FETCH, or DONE when index+1 = trace_len.
- Counters saturate at 2^CNT_W−1; no wrap. hit+miss=access while unsaturated.
- WAYS=1: direct-mapped. Ages and pointers are unused, and the victim is always way 0.
- start while busy: ignored. start in DONE: new run, clearing state as above.

## Timing
- Reset values: mem_csb=1, mem_addr=0, busy=0, done=0, all counters 0, all valid bits 0, state IDLE.
- mem_csb=0 only during FETCH. mem_addr holds its value outside FETCH.
- Start sampled at edge E. FLUSH runs from E to E+1. Each entry takes 4 cycles (FETCH, WAIT, LOOKUP, UPDATE).
- DONE is entered, with done=1 and busy=0, at edge E+1+4·trace_len.
- busy=1 from E through the last UPDATE.
- Counters update at the end of UPDATE. They are stable and valid whenever done=1.
- Reset asserted mid-run: at the next edge, return to reset values. No partial counts persist.

## Test plan
- Default params, LRU, trace {0x00,0x04,0x00,0x01}, trace_len=4 -> done at E+17; access=4, hit=2, miss=2, evict=0.
- Set-0 conflict trace {0x00,0x10,0x00,0x20,0x10}, WAYS=2:
  - repl_mode=0 (LRU) -> access=5, hit=1, miss=4, evict=2.
  - repl_mode=1 (FIFO) -> access=5, hit=2, miss=3, evict=1.
- CNT_W=3, trace of 10 copies of 0x40 -> access=7, hit=7, miss=1, evict=0 (saturated).
- trace_len=0 -> done at E+1, all counters 0, mem_csb never low. Pulse start while busy -> ignored; the run's counts are unchanged.
- Reset during the third entry's LOOKUP -> next cycle busy=0, done=0, counters 0. Rerun of trace 1 gives identical results.
- Back-to-back: start in DONE after trace 1 -> counters cleared, cache flushed. Rerunning trace 1 reproduces hit=2, not 4.
